// File: rtl/rob_nport_pkg.sv
// Shared types for the rob_nport reorder buffer: ROB entry and CDB result layouts.
package rob_nport_pkg;

  localparam int XLEN      = 32;
  localparam int CDB_IDX_W = 8;
  localparam int EXC_W     = 5;

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [4:0]       rd_idx;
    logic             res_ready;
    logic [XLEN-1:0]  res_value;
    logic             except_raised;
    logic [EXC_W-1:0] except_code;
  } rob_entry_t;

  typedef struct packed {
    logic [CDB_IDX_W-1:0] rob_idx;
    logic [XLEN-1:0]      res_value;
    logic                 except_raised;
    logic [EXC_W-1:0]     except_code;
  } cdb_data_t;

endpackage

// File: rtl/rob_nport_if.sv
// Issue, commit, lookup, CDB and squash/flush signals of rob_nport.
// master = pipeline side driving the ROB, slave = the ROB itself.
interface rob_nport_if #(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2
);
  localparam int IDXW = $clog2(DEPTH);

  logic                                          flush_i;
  logic                                          squash_valid_i;
  logic [IDXW-1:0]                               squash_idx_i;
  logic                                          issue_valid_i;
  logic                                          issue_ready_o;
  rob_nport_pkg::rob_entry_t                     issue_data_i;
  logic [IDXW-1:0]                               issue_tail_idx_o;
  logic [IDXW-1:0]                               issue_rs1_rob_idx_i;
  logic [IDXW-1:0]                               issue_rs2_rob_idx_i;
  logic                                          issue_rs1_ready_o;
  logic                                          issue_rs2_ready_o;
  logic [rob_nport_pkg::XLEN-1:0]                issue_rs1_value_o;
  logic [rob_nport_pkg::XLEN-1:0]                issue_rs2_value_o;
  logic [IDXW:0]                                 occupancy_o;
  logic                                          comm_valid_o;
  logic                                          comm_ready_i;
  rob_nport_pkg::rob_entry_t                     comm_data_o;
  logic [IDXW-1:0]                               comm_head_idx_o;
  logic [NUM_CDB-1:0]                            cdb_valid_i;
  rob_nport_pkg::cdb_data_t [NUM_CDB-1:0]        cdb_data_i;

  modport master (
    output flush_i, squash_valid_i, squash_idx_i,
    output issue_valid_i, issue_data_i, issue_rs1_rob_idx_i, issue_rs2_rob_idx_i,
    output comm_ready_i, cdb_valid_i, cdb_data_i,
    input  issue_ready_o, issue_tail_idx_o, issue_rs1_ready_o, issue_rs2_ready_o,
    input  issue_rs1_value_o, issue_rs2_value_o, occupancy_o,
    input  comm_valid_o, comm_data_o, comm_head_idx_o
  );

  modport slave (
    input  flush_i, squash_valid_i, squash_idx_i,
    input  issue_valid_i, issue_data_i, issue_rs1_rob_idx_i, issue_rs2_rob_idx_i,
    input  comm_ready_i, cdb_valid_i, cdb_data_i,
    output issue_ready_o, issue_tail_idx_o, issue_rs1_ready_o, issue_rs2_ready_o,
    output issue_rs1_value_o, issue_rs2_value_o, occupancy_o,
    output comm_valid_o, comm_data_o, comm_head_idx_o
  );

endinterface

// File: rtl/rob_nport.sv
// Reorder buffer with NUM_CDB result write ports, full flush and partial squash.
// Optional ROB_CDB_BYPASS_EN forwards same-cycle CDB results to operand lookups.
module rob_nport
  import rob_nport_pkg::*;
#(
  parameter int DEPTH   = 8,
  parameter int NUM_CDB = 2
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  rob_nport_if.slave rob_if
);
  localparam int IDXW = $clog2(DEPTH);
  localparam int CNTW = IDXW + 1;

  logic [IDXW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  rob_entry_t       data_q [DEPTH];
  rob_entry_t       data_d [DEPTH];

  logic             issue_ready, comm_valid, push, pop, squash;
  logic [IDXW-1:0]  sq_dist;
  logic [DEPTH-1:0] squashed;
  logic [DEPTH-1:0] cdb_hit;
  cdb_data_t        cdb_sel [DEPTH];
  logic [IDXW-1:0]  rs_idx   [2];
  logic             rs_ready [2];
  logic [XLEN-1:0]  rs_value [2];

  assign issue_ready = (count_q != CNTW'(DEPTH)) && !rob_if.squash_valid_i && !rob_if.flush_i;
  assign comm_valid  = (count_q != '0);
  assign push        = rob_if.issue_valid_i && issue_ready;
  assign pop         = comm_valid && rob_if.comm_ready_i;
  assign squash      = rob_if.squash_valid_i && !rob_if.flush_i;
  assign sq_dist     = rob_if.squash_idx_i - head_q;

  // Entries further from head than the mispredicted instruction are younger and get dropped.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      squashed[i] = squash && ((IDXW'(i) - head_q) > sq_dist);
    end
  end

  // Per-entry CDB port select; scanning downwards lets the lowest-numbered port win.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      cdb_hit[i] = 1'b0;
      cdb_sel[i] = '0;
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (rob_if.cdb_valid_i[k] && (rob_if.cdb_data_i[k].rob_idx[IDXW-1:0] == IDXW'(i))) begin
          cdb_hit[i] = 1'b1;
          cdb_sel[i] = rob_if.cdb_data_i[k];
        end
      end
    end
  end

  for (genvar k = 0; k < NUM_CDB; k++) begin : g_cdb
    logic unused_idx_hi;
    assign unused_idx_hi = ^rob_if.cdb_data_i[k].rob_idx[CDB_IDX_W-1:IDXW];

    for (genvar j = k + 1; j < NUM_CDB; j++) begin : g_pair
      a_cdb_idx_unique : assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(rob_if.cdb_valid_i[k] && rob_if.cdb_valid_i[j] &&
          (rob_if.cdb_data_i[k].rob_idx[IDXW-1:0] == rob_if.cdb_data_i[j].rob_idx[IDXW-1:0])));
    end
  end

  a_squash_idx_valid : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    squash |-> valid_q[rob_if.squash_idx_i]);

  // NOTE: every next-state variable takes its current value first, so no path can infer a latch.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    data_d  = data_q;
    if (rob_if.flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cdb_hit[i] && valid_q[i] && !squashed[i] && !(push && (tail_q == IDXW'(i)))) begin
          data_d[i].res_ready     = 1'b1;
          data_d[i].res_value     = cdb_sel[i].res_value;
          data_d[i].except_raised = cdb_sel[i].except_raised;
          data_d[i].except_code   = cdb_sel[i].except_code;
        end
      end
      if (push) begin
        data_d[tail_q]  = rob_if.issue_data_i;
        valid_d[tail_q] = 1'b1;
        tail_d          = tail_q + IDXW'(1);
      end
      if (pop) begin
        valid_d[head_q] = 1'b0;
        head_d          = head_q + IDXW'(1);
      end
      count_d = count_q + CNTW'(push) - CNTW'(pop);
      if (squash) begin
        valid_d = valid_d & ~squashed;
        tail_d  = rob_if.squash_idx_i + IDXW'(1);
        count_d = CNTW'(sq_dist) + CNTW'(1) - CNTW'(pop);
      end
    end
  end

  // NOTE: the entry array is reset too, because its contents are visible on comm_data_o and the lookup values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
    end else begin
      // NOTE: non-blocking updates keep all state reading pre-edge values regardless of statement order.
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rs_idx[0] = rob_if.issue_rs1_rob_idx_i;
  assign rs_idx[1] = rob_if.issue_rs2_rob_idx_i;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_ready[p] = valid_q[rs_idx[p]] && data_q[rs_idx[p]].res_ready;
      rs_value[p] = data_q[rs_idx[p]].res_value;
`ifdef ROB_CDB_BYPASS_EN
      if (valid_q[rs_idx[p]] && cdb_hit[rs_idx[p]]) begin
        rs_ready[p] = 1'b1;
        rs_value[p] = cdb_sel[rs_idx[p]].res_value;
      end
`endif
    end
  end

  assign rob_if.issue_ready_o     = issue_ready;
  assign rob_if.issue_tail_idx_o  = tail_q;
  assign rob_if.occupancy_o       = count_q;
  assign rob_if.comm_valid_o      = comm_valid;
  assign rob_if.comm_data_o       = data_q[head_q];
  assign rob_if.comm_head_idx_o   = head_q;
  assign rob_if.issue_rs1_ready_o = rs_ready[0];
  assign rob_if.issue_rs1_value_o = rs_value[0];
  assign rob_if.issue_rs2_ready_o = rs_ready[1];
  assign rob_if.issue_rs2_value_o = rs_value[1];

endmodule

// File: tb/tb_rob_nport.sv
// Directed bench for rob_nport: queue-based reference model checked every cycle, plus literal checkpoints.
module tb_rob_nport;
  import rob_nport_pkg::*;

  localparam int DEPTH   = 8;
  localparam int NUM_CDB = 2;
  localparam int IDXW    = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rob_nport_if #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) bus ();

  rob_nport #(.DEPTH(DEPTH), .NUM_CDB(NUM_CDB)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .rob_if  (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: program-ordered queue of occupied slots plus a plain data store.
  rob_entry_t m_mem [DEPTH];
  int         m_q[$];
  int         m_head;

  function automatic int m_pos(input int idx);
    foreach (m_q[p]) if (m_q[p] == idx) return p;
    return -1;
  endfunction

  function automatic bit exp_issue_ready();
    return (m_q.size() < DEPTH) && !bus.squash_valid_i && !bus.flush_i;
  endfunction

  function automatic int m_tail();
    return (m_head + m_q.size()) % DEPTH;
  endfunction

  task automatic exp_lookup(input int idx, output bit rdy, output logic [XLEN-1:0] val);
    rdy = (m_pos(idx) >= 0) && m_mem[idx].res_ready;
    val = m_mem[idx].res_value;
`ifdef ROB_CDB_BYPASS_EN
    if (m_pos(idx) >= 0) begin
      for (int k = 0; k < NUM_CDB; k++) begin
        if (bus.cdb_valid_i[k] && (int'(bus.cdb_data_i[k].rob_idx) % DEPTH == idx)) begin
          rdy = 1'b1;
          val = bus.cdb_data_i[k].res_value;
          break;
        end
      end
    end
`endif
  endtask

  task automatic m_reset();
    m_q.delete();
    m_head = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
  endtask

  task automatic m_step();
    int size, kept, tail, idx, p;
    bit push, pop;
    bit [DEPTH-1:0] done;
    size = m_q.size();
    push = bus.issue_valid_i && exp_issue_ready();
    pop  = (size > 0) && bus.comm_ready_i;
    if (bus.flush_i) begin
      m_q.delete();
      m_head = 0;
      return;
    end
    kept = size;
    if (bus.squash_valid_i) kept = ((int'(bus.squash_idx_i) - m_head + DEPTH) % DEPTH) + 1;
    tail = m_tail();
    done = '0;
    for (int k = 0; k < NUM_CDB; k++) begin
      if (bus.cdb_valid_i[k]) begin
        idx = int'(bus.cdb_data_i[k].rob_idx) % DEPTH;
        if (!done[idx]) begin
          done[idx] = 1'b1;
          p = m_pos(idx);
          if (p >= 0 && p < kept && !(push && idx == tail)) begin
            m_mem[idx].res_ready     = 1'b1;
            m_mem[idx].res_value     = bus.cdb_data_i[k].res_value;
            m_mem[idx].except_raised = bus.cdb_data_i[k].except_raised;
            m_mem[idx].except_code   = bus.cdb_data_i[k].except_code;
          end
        end
      end
    end
    while (m_q.size() > kept) void'(m_q.pop_back());
    if (pop) begin
      void'(m_q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
    if (push) begin
      m_mem[tail] = bus.issue_data_i;
      m_q.push_back(tail);
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    bit rdy;
    logic [XLEN-1:0] val;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("issue_ready", bus.issue_ready_o, exp_issue_ready());
        check("tail_idx", bus.issue_tail_idx_o, m_tail());
        check("occupancy", bus.occupancy_o, m_q.size());
        check("comm_valid", bus.comm_valid_o, m_q.size() > 0);
        check("comm_data", bus.comm_data_o, m_mem[m_head]);
        check("head_idx", bus.comm_head_idx_o, m_head);
        exp_lookup(int'(bus.issue_rs1_rob_idx_i), rdy, val);
        check("rs1_ready", bus.issue_rs1_ready_o, rdy);
        check("rs1_value", bus.issue_rs1_value_o, val);
        exp_lookup(int'(bus.issue_rs2_rob_idx_i), rdy, val);
        check("rs2_ready", bus.issue_rs2_ready_o, rdy);
        check("rs2_value", bus.issue_rs2_value_o, val);
      end
    end
  end

  function automatic rob_entry_t mk_entry(input int n);
    rob_entry_t e;
    e        = '0;
    e.pc     = 32'h100 + n;
    e.rd_idx = 5'(n);
    return e;
  endfunction

  function automatic cdb_data_t mk_cdb(input int idx, input logic [XLEN-1:0] val);
    cdb_data_t c;
    c           = '0;
    c.rob_idx   = CDB_IDX_W'(idx);
    c.res_value = val;
    return c;
  endfunction

  task automatic idle();
    bus.flush_i             = 1'b0;
    bus.squash_valid_i      = 1'b0;
    bus.squash_idx_i        = '0;
    bus.issue_valid_i       = 1'b0;
    bus.issue_data_i        = '0;
    bus.issue_rs1_rob_idx_i = '0;
    bus.issue_rs2_rob_idx_i = '0;
    bus.comm_ready_i        = 1'b0;
    bus.cdb_valid_i         = '0;
    bus.cdb_data_i          = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_n(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      bus.issue_valid_i = 1'b1;
      bus.issue_data_i  = mk_entry(base + i);
      step();
    end
    bus.issue_valid_i = 1'b0;
  endtask

  task automatic check_reset_values();
    check("rst_issue_ready", bus.issue_ready_o, 1'b1);
    check("rst_tail_idx", bus.issue_tail_idx_o, 0);
    check("rst_occupancy", bus.occupancy_o, 0);
    check("rst_comm_valid", bus.comm_valid_o, 1'b0);
    check("rst_comm_data", bus.comm_data_o, 0);
    check("rst_head_idx", bus.comm_head_idx_o, 0);
    check("rst_rs1_ready", bus.issue_rs1_ready_o, 1'b0);
    check("rst_rs1_value", bus.issue_rs1_value_o, 0);
    check("rst_rs2_ready", bus.issue_rs2_ready_o, 1'b0);
    check("rst_rs2_value", bus.issue_rs2_value_o, 0);
  endtask

  initial begin
    idle();
    #3;
    check_reset_values();
    #9 rst_n = 1'b1;
    step();

    // Fill to capacity, then a pop does not free a slot for a same-cycle push.
    push_n(8, 0);
    check("full_occupancy", bus.occupancy_o, 8);
    check("full_ready", bus.issue_ready_o, 1'b0);
    check("full_tail_wrap", bus.issue_tail_idx_o, 0);
    check("full_head_pc", bus.comm_data_o.pc, 32'h100);
    bus.issue_valid_i = 1'b1;
    bus.issue_data_i  = mk_entry(8);
    bus.comm_ready_i  = 1'b1;
    #1;
    check("full_pop_no_ready", bus.issue_ready_o, 1'b0);
    step();
    idle();
    check("pop_occupancy", bus.occupancy_o, 7);
    check("pop_head", bus.comm_head_idx_o, 1);
    push_n(1, 8);
    check("refill_occupancy", bus.occupancy_o, 8);
    check("refill_tail", bus.issue_tail_idx_o, 1);
    bus.flush_i = 1'b1;
    step();
    idle();

    // Two CDB ports in one cycle.
    push_n(3, 16);
    bus.cdb_valid_i         = 2'b11;
    bus.cdb_data_i[0]       = mk_cdb(2, 32'hAA);
    bus.cdb_data_i[1]       = mk_cdb(0, 32'h55);
    bus.issue_rs1_rob_idx_i = 3'd0;
    bus.issue_rs2_rob_idx_i = 3'd2;
    step();
    bus.cdb_valid_i = '0;
    #1;
    check("cdb_rs1_ready", bus.issue_rs1_ready_o, 1'b1);
    check("cdb_rs1_value", bus.issue_rs1_value_o, 32'h55);
    check("cdb_rs2_ready", bus.issue_rs2_ready_o, 1'b1);
    check("cdb_rs2_value", bus.issue_rs2_value_o, 32'hAA);
    check("cdb_commit_value", bus.comm_data_o.res_value, 32'h55);
    bus.comm_ready_i = 1'b1;
    step();
    idle();
    check("cdb_pop_head", bus.comm_head_idx_o, 1);
    check("cdb_pop_occupancy", bus.occupancy_o, 2);
    bus.flush_i = 1'b1;
    step();
    idle();

    // Walk head to 6, then fill 6,7,0,1,2,3 and squash at 0.
    bus.comm_ready_i = 1'b1;
    push_n(6, 32);
    step();
    bus.comm_ready_i = 1'b0;
    check("walk_head", bus.comm_head_idx_o, 6);
    check("walk_empty", bus.occupancy_o, 0);
    push_n(6, 40);
    check("sq_pre_occupancy", bus.occupancy_o, 6);
    check("sq_pre_tail", bus.issue_tail_idx_o, 4);
    bus.squash_valid_i = 1'b1;
    bus.squash_idx_i   = 3'd0;
    bus.cdb_valid_i    = 2'b11;
    bus.cdb_data_i[0]  = mk_cdb(2, 32'hDEAD);
    bus.cdb_data_i[1]  = mk_cdb(7, 32'h77);
    #1;
    check("sq_ready_drop", bus.issue_ready_o, 1'b0);
    step();
    idle();
    bus.issue_rs1_rob_idx_i = 3'd2;
    bus.issue_rs2_rob_idx_i = 3'd7;
    #1;
    check("sq_tail", bus.issue_tail_idx_o, 1);
    check("sq_occupancy", bus.occupancy_o, 3);
    check("sq_head", bus.comm_head_idx_o, 6);
    check("sq_dropped_ready", bus.issue_rs1_ready_o, 1'b0);
    check("sq_dropped_value", bus.issue_rs1_value_o, 0);
    check("sq_kept_ready", bus.issue_rs2_ready_o, 1'b1);
    check("sq_kept_value", bus.issue_rs2_value_o, 32'h77);

    // Squash at head together with a pop empties the ROB.
    bus.squash_valid_i = 1'b1;
    bus.squash_idx_i   = 3'd6;
    bus.comm_ready_i   = 1'b1;
    step();
    idle();
    check("sqpop_occupancy", bus.occupancy_o, 0);
    check("sqpop_comm_valid", bus.comm_valid_o, 1'b0);
    check("sqpop_head", bus.comm_head_idx_o, 7);
    check("sqpop_tail", bus.issue_tail_idx_o, 7);

    // Lookup of an entry being written on the CDB in the same cycle.
    push_n(6, 48);
    bus.issue_rs1_rob_idx_i = 3'd4;
    bus.cdb_valid_i         = 2'b10;
    bus.cdb_data_i[1]       = mk_cdb(4, 32'h1234);
    #1;
`ifdef ROB_CDB_BYPASS_EN
    check("byp_same_ready", bus.issue_rs1_ready_o, 1'b1);
    check("byp_same_value", bus.issue_rs1_value_o, 32'h1234);
`else
    check("byp_same_ready", bus.issue_rs1_ready_o, 1'b0);
`endif
    step();
    bus.cdb_valid_i = '0;
    #1;
    check("byp_next_ready", bus.issue_rs1_ready_o, 1'b1);
    check("byp_next_value", bus.issue_rs1_value_o, 32'h1234);

    // Flush beats push, pop and CDB.
    bus.issue_valid_i = 1'b1;
    bus.issue_data_i  = mk_entry(60);
    bus.comm_ready_i  = 1'b1;
    bus.cdb_valid_i   = 2'b01;
    bus.cdb_data_i[0] = mk_cdb(0, 32'h99);
    bus.flush_i       = 1'b1;
    #1;
    check("flush_ready_drop", bus.issue_ready_o, 1'b0);
    step();
    idle();
    check("flush_occupancy", bus.occupancy_o, 0);
    check("flush_head", bus.comm_head_idx_o, 0);
    check("flush_tail", bus.issue_tail_idx_o, 0);
    check("flush_comm_valid", bus.comm_valid_o, 1'b0);

    // Asynchronous reset in the middle of traffic.
    push_n(3, 70);
    bus.cdb_valid_i   = 2'b01;
    bus.cdb_data_i[0] = mk_cdb(0, 32'h5A5A);
    step();
    bus.cdb_valid_i = '0;
    #1;
    check("pre_rst_value", bus.comm_data_o.res_value, 32'h5A5A);
    #1 rst_n = 1'b0;
    #1;
    check_reset_values();
    #10 rst_n = 1'b1;
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
